// File: rtl/s3g_pkg.sv
// rtl/s3g_pkg.sv - shared S3G framing constants and transmitter state encoding
package s3g_pkg;

   localparam logic [7:0] S3G_START      = 8'hD5;
   localparam logic [7:0] CRC8_POLY_REFL = 8'h8C;
   localparam logic [7:0] CRC8_INIT      = 8'h00;

   typedef enum logic [2:0] {
      ST_FILL = 3'd0,
      ST_DROP = 3'd1,
      ST_SEND = 3'd2,
      ST_WAIT = 3'd3,
      ST_GAP  = 3'd4
   } tx_state_e;

   // Byte index within a frame: 0 start, 1 length, 2.. payload, len+2 CRC
   localparam logic [8:0] IDX_HDR = 9'd0;
   localparam logic [8:0] IDX_LEN = 9'd1;

endpackage

// File: rtl/s3g_crc8_byte.sv
// rtl/s3g_crc8_byte.sv - combinational single-byte S3G CRC8 (Dallas/iButton) update
module s3g_crc8_byte
   import s3g_pkg::*;
(
   input  logic [7:0] crc_in,
   input  logic [7:0] data,
   output logic [7:0] crc_out
);

   logic [7:0] c;

   always_comb begin
      c = crc_in ^ data;
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ CRC8_POLY_REFL) : (c >> 1);
      end
      crc_out = c;
   end

endmodule

// File: rtl/s3g_frame_tx.sv
// rtl/s3g_frame_tx.sv - buffers a payload and emits 0xD5, len, payload, CRC8 to the UART tx handshake
module s3g_frame_tx
   import s3g_pkg::*;
#(
   parameter int MAX_PAYLOAD = 64,
   parameter int ADDR_W      = 6,
   parameter int GAP_CYCLES  = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  pl_data,
   input  logic        pl_valid,
   input  logic        pl_last,
   output logic        pl_ready,
   output logic [7:0]  tx_data,
   output logic        tx_wr,
   input  logic        tx_done,
   output logic        busy,
   output logic        frame_done,
   output logic        err_overflow,
   output logic [15:0] frames_sent
);

   localparam logic [ADDR_W:0] MAX_CNT  = (ADDR_W + 1)'(MAX_PAYLOAD);
   localparam logic [15:0]     GAP_LAST = (GAP_CYCLES > 0) ? 16'(GAP_CYCLES - 1) : 16'd0;

   tx_state_e       state_q, state_d;
   logic [ADDR_W:0] count_q, count_d;
   logic [7:0]      len_q, len_d;
   logic [7:0]      crc_q, crc_d;
   logic [8:0]      idx_q, idx_d;
   logic [15:0]     gap_q, gap_d;
   logic [15:0]     frames_q, frames_d;
   logic            frame_done_q, frame_done_d;
   logic            err_q, err_d;

   logic [7:0]        crc_upd;
   logic [8:0]        last_idx;
   logic              full;
   logic              wr_en;
   logic              rd_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [ADDR_W-1:0] rd_addr;
   logic [7:0]        rd_data_q;
   logic [7:0]        mem_q [0:(2**ADDR_W)-1];

   s3g_crc8_byte u_crc (
      .crc_in  (crc_q),
      .data    (pl_data),
      .crc_out (crc_upd)
   );

   assign full     = (count_q == MAX_CNT);
   assign last_idx = {1'b0, len_q} + 9'd2;
   assign wr_addr  = count_q[ADDR_W-1:0];
   // The read is issued on the edge entering SEND for the byte after idx_q
   assign rd_addr  = ADDR_W'(idx_q - 9'd1);

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= pl_data;
      end
      if (rd_en) begin
         rd_data_q <= mem_q[rd_addr];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_FILL;
         count_q      <= '0;
         len_q        <= 8'h00;
         crc_q        <= CRC8_INIT;
         idx_q        <= IDX_HDR;
         gap_q        <= 16'h0000;
         frames_q     <= 16'h0000;
         frame_done_q <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         len_q        <= len_d;
         crc_q        <= crc_d;
         idx_q        <= idx_d;
         gap_q        <= gap_d;
         frames_q     <= frames_d;
         frame_done_q <= frame_done_d;
         err_q        <= err_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      count_d      = count_q;
      len_d        = len_q;
      crc_d        = crc_q;
      idx_d        = idx_q;
      gap_d        = gap_q;
      frames_d     = frames_q;
      frame_done_d = 1'b0;
      err_d        = 1'b0;
      wr_en        = 1'b0;
      rd_en        = 1'b0;
      case (state_q)
         ST_FILL: begin
            if (pl_valid) begin
               if (full) begin
                  count_d = '0;
                  crc_d   = CRC8_INIT;
                  if (pl_last) begin
                     err_d = 1'b1;
                  end else begin
                     state_d = ST_DROP;
                  end
               end else begin
                  wr_en   = 1'b1;
                  count_d = count_q + 1'b1;
                  crc_d   = crc_upd;
                  if (pl_last) begin
                     len_d   = 8'(count_q + 1'b1);
                     idx_d   = IDX_HDR;
                     state_d = ST_SEND;
                  end
               end
            end
         end
         ST_DROP: begin
            if (pl_valid && pl_last) begin
               err_d   = 1'b1;
               count_d = '0;
               crc_d   = CRC8_INIT;
               state_d = ST_FILL;
            end
         end
         ST_SEND: begin
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (tx_done) begin
               if (idx_q == last_idx) begin
                  frame_done_d = 1'b1;
                  frames_d     = frames_q + 16'd1;
                  count_d      = '0;
                  crc_d        = CRC8_INIT;
                  state_d      = ST_FILL;
               end else if (GAP_CYCLES > 0) begin
                  gap_d   = 16'h0000;
                  state_d = ST_GAP;
               end else begin
                  rd_en   = 1'b1;
                  idx_d   = idx_q + 9'd1;
                  state_d = ST_SEND;
               end
            end
         end
         ST_GAP: begin
            if (gap_q == GAP_LAST) begin
               rd_en   = 1'b1;
               idx_d   = idx_q + 9'd1;
               state_d = ST_SEND;
            end else begin
               gap_d = gap_q + 16'd1;
            end
         end
         default: begin
            state_d = ST_FILL;
         end
      endcase
   end

   always_comb begin
      tx_data = 8'h00;
      if (state_q == ST_SEND || state_q == ST_WAIT || state_q == ST_GAP) begin
         if (idx_q == IDX_HDR) begin
            tx_data = S3G_START;
         end else if (idx_q == IDX_LEN) begin
            tx_data = len_q;
         end else if (idx_q == last_idx) begin
            tx_data = crc_q;
         end else begin
            tx_data = rd_data_q;
         end
      end
   end

   assign tx_wr        = (state_q == ST_SEND);
   assign pl_ready     = (state_q == ST_FILL) || (state_q == ST_DROP);
   assign busy         = (state_q != ST_FILL);
   assign frame_done   = frame_done_q;
   assign err_overflow = err_q;
   assign frames_sent  = frames_q;

endmodule

// File: tb/tb_s3g_frame_tx.sv
// tb/tb_s3g_frame_tx.sv - directed self-checking bench for s3g_frame_tx
module tb_s3g_frame_tx;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, pl_valid, pl_last, tx_done, sel;
   logic [7:0]  pl_data;
   logic        pl_ready0, tx_wr0, busy0, fd0, err0;
   logic        pl_ready1, tx_wr1, busy1, fd1, err1;
   logic [7:0]  tx_data0, tx_data1;
   logic [15:0] fs0, fs1;
   logic        pl_valid0, pl_valid1, tx_done0, tx_done1;
   logic        pl_ready_m, tx_wr_m, busy_m, fd_m, err_m;
   logic [7:0]  tx_data_m;
   logic [15:0] fs_m;

   assign pl_valid0  = pl_valid & ~sel;
   assign pl_valid1  = pl_valid & sel;
   assign tx_done0   = tx_done & ~sel;
   assign tx_done1   = tx_done & sel;
   assign pl_ready_m = sel ? pl_ready1 : pl_ready0;
   assign tx_wr_m    = sel ? tx_wr1 : tx_wr0;
   assign busy_m     = sel ? busy1 : busy0;
   assign fd_m       = sel ? fd1 : fd0;
   assign err_m      = sel ? err1 : err0;
   assign tx_data_m  = sel ? tx_data1 : tx_data0;
   assign fs_m       = sel ? fs1 : fs0;

   s3g_frame_tx #(.MAX_PAYLOAD(64), .ADDR_W(6), .GAP_CYCLES(0)) u_dut0 (
      .clk(clk), .rst(rst), .pl_data(pl_data), .pl_valid(pl_valid0), .pl_last(pl_last),
      .pl_ready(pl_ready0), .tx_data(tx_data0), .tx_wr(tx_wr0), .tx_done(tx_done0),
      .busy(busy0), .frame_done(fd0), .err_overflow(err0), .frames_sent(fs0)
   );

   s3g_frame_tx #(.MAX_PAYLOAD(4), .ADDR_W(2), .GAP_CYCLES(5)) u_dut1 (
      .clk(clk), .rst(rst), .pl_data(pl_data), .pl_valid(pl_valid1), .pl_last(pl_last),
      .pl_ready(pl_ready1), .tx_data(tx_data1), .tx_wr(tx_wr1), .tx_done(tx_done1),
      .busy(busy1), .frame_done(fd1), .err_overflow(err1), .frames_sent(fs1)
   );

   int cyc = 0;
   int wr_cnt = 0;
   int done_cyc = -1;
   int n_chk = 0;
   int n_pass = 0;
   logic [7:0] pl_buf [4];
   int pl_n;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (tx_wr_m) wr_cnt <= wr_cnt + 1;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   function automatic logic [7:0] crc8_model(input int n);
      logic [7:0] c;
      c = 8'h00;
      for (int i = 0; i < n; i++) begin
         c = c ^ pl_buf[i];
         for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 8'h8C) : (c >> 1);
      end
      return c;
   endfunction

   task automatic set_pl(input logic [7:0] b0, b1, b2, b3, input int n);
      pl_buf[0] = b0; pl_buf[1] = b1; pl_buf[2] = b2; pl_buf[3] = b3;
      pl_n = n;
   endtask

   task automatic push_byte(input logic [7:0] d, input logic last);
      pl_data = d; pl_valid = 1'b1; pl_last = last;
      @(negedge clk);
   endtask

   task automatic xfer(input logic [7:0] exp, input int dly, input logic early);
      int n;
      n = 0;
      while (tx_wr_m !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check_eq("tx_wr_seen", tx_wr_m, 1);
      check_eq("tx_data", tx_data_m, exp);
      check_eq("ready_busy_in_frame", {pl_ready_m, busy_m}, 2'b01);
      if (done_cyc >= 0) check_eq("wr_after_done", cyc - done_cyc, sel ? 6 : 1);
      tx_done = early;
      @(negedge clk);
      tx_done = 1'b0;
      check_eq("tx_wr_one_cycle", tx_wr_m, 0);
      repeat (dly - 1) @(negedge clk);
      check_eq("tx_data_hold", tx_data_m, exp);
      tx_done = 1'b1;
      done_cyc = cyc;
      @(negedge clk);
      tx_done = 1'b0;
   endtask

   task automatic run_frame(input logic [7:0] crc, input int dly, input logic early, input logic [15:0] exp_fs);
      for (int i = 0; i < pl_n; i++) push_byte(pl_buf[i], i == pl_n - 1);
      pl_valid = 1'b0; pl_last = 1'b0;
      check_eq("first_wr_latency", tx_wr_m, 1);
      done_cyc = -1;
      for (int i = 0; i < pl_n + 3; i++) begin
         if (i == 0) xfer(8'hD5, dly, early);
         else if (i == 1) xfer(8'(pl_n), dly, early);
         else if (i == pl_n + 2) xfer(crc, dly, early);
         else xfer(pl_buf[i-2], dly, early);
      end
      check_eq("frame_done", fd_m, 1);
      check_eq("frames_sent", fs_m, exp_fs);
      check_eq("ready_after_frame", pl_ready_m, 1);
      @(negedge clk);
      check_eq("frame_done_one_cycle", fd_m, 0);
   endtask

   initial begin
      int w0;
      rst = 1'b1; pl_valid = 1'b0; pl_last = 1'b0; pl_data = 8'h00; tx_done = 1'b0; sel = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst_outputs", {pl_ready0, tx_wr0, busy0, fd0, err0}, 5'b10000);
      check_eq("rst_tx_data", tx_data0, 8'h00);
      check_eq("rst_frames0", fs0, 16'h0000);
      check_eq("rst_frames1", fs1, 16'h0000);
      rst = 1'b0;
      @(negedge clk);

      set_pl(8'h01, 8'h00, 8'h00, 8'h00, 1);
      run_frame(8'h5E, 10, 1'b0, 16'd1);
      set_pl(8'h00, 8'h00, 8'h00, 8'h00, 1);
      run_frame(8'h00, 10, 1'b0, 16'd2);

      // abandon a frame while waiting on its second payload byte
      push_byte(8'hAA, 1'b0);
      push_byte(8'hBB, 1'b1);
      pl_valid = 1'b0; pl_last = 1'b0;
      done_cyc = -1;
      xfer(8'hD5, 10, 1'b0);
      xfer(8'h02, 10, 1'b0);
      xfer(8'hAA, 10, 1'b0);
      repeat (2) @(negedge clk);
      check_eq("rst_test_wr_bb", {tx_wr_m, tx_data_m}, {1'b0, 8'hBB});
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_eq("midrst_outputs", {pl_ready0, tx_wr0, busy0}, 3'b100);
      check_eq("midrst_frames", fs0, 16'h0000);
      w0 = wr_cnt;
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
      repeat (4) @(negedge clk);
      check_eq("stale_done_ignored", wr_cnt - w0, 0);
      set_pl(8'h01, 8'h00, 8'h00, 8'h00, 1);
      run_frame(8'h5E, 10, 1'b0, 16'd1);

      force u_dut0.frames_q = 16'hFFFF;
      @(negedge clk);
      release u_dut0.frames_q;
      check_eq("frames_preset", fs0, 16'hFFFF);
      set_pl(8'h00, 8'h00, 8'h00, 8'h00, 1);
      run_frame(8'h00, 1, 1'b1, 16'h0000);
      set_pl(8'h01, 8'h00, 8'h00, 8'h00, 3);
      run_frame(crc8_model(3), 1, 1'b1, 16'h0001);

      sel = 1'b1;
      @(negedge clk);
      set_pl(8'h12, 8'h34, 8'h56, 8'h00, 3);
      w0 = wr_cnt;
      run_frame(crc8_model(3), 3, 1'b0, 16'd1);
      check_eq("gap_wr_strobes", wr_cnt - w0, 6);

      // six bytes into a four-byte buffer, last on the sixth
      w0 = wr_cnt;
      for (int i = 0; i < 5; i++) push_byte(8'(8'h10 + i), 1'b0);
      check_eq("drop_ready_busy", {pl_ready_m, busy_m, err_m}, 3'b110);
      push_byte(8'h15, 1'b1);
      pl_valid = 1'b0; pl_last = 1'b0;
      check_eq("ovf_pulse_drop", err_m, 1);
      @(negedge clk);
      check_eq("ovf_one_cycle", err_m, 0);
      check_eq("ovf_state", {pl_ready_m, busy_m}, 2'b10);

      // overflow byte carries pl_last: immediate drop, no DROP state
      for (int i = 0; i < 4; i++) push_byte(8'(8'h20 + i), 1'b0);
      push_byte(8'h24, 1'b1);
      pl_valid = 1'b0; pl_last = 1'b0;
      check_eq("ovf_pulse_last", {err_m, busy_m}, 2'b10);
      repeat (3) @(negedge clk);
      check_eq("ovf_no_tx", wr_cnt - w0, 0);
      check_eq("ovf_frames", fs_m, 16'd1);

      set_pl(8'h01, 8'h02, 8'h03, 8'h04, 4);
      run_frame(crc8_model(4), 2, 1'b0, 16'd2);
      set_pl(8'h01, 8'h00, 8'h00, 8'h00, 1);
      run_frame(8'h5E, 10, 1'b0, 16'd3);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
